// File: rtl/vram_pkg.sv
// vram_pkg: shared VRAM geometry, write-FIFO entry layout and debug sequencer states
package vram_pkg;
    localparam int PIX_W       = 12;
    localparam int ROW_W       = 9;
    localparam int COL_W       = 10;
    localparam int ADDR_W      = 19;
    localparam int H_ACT       = 640;
    localparam int V_ACT       = 480;
    localparam int WFIFO_DEPTH = 4;

    localparam logic [0:0] ST_DISP = 1'b0;
    localparam logic [0:0] ST_FREE = 1'b1;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [PIX_W-1:0] data;
    } wr_entry_t;

    function automatic logic on_screen(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
        return (row < ROW_W'(V_ACT)) && (col < COL_W'(H_ACT));
    endfunction
endpackage

// File: rtl/vram_wfifo.sv
// vram_wfifo: show-ahead write FIFO; pushes while full and pops while empty are ignored
module vram_wfifo
    import vram_pkg::*;
#(
    parameter int DEPTH = WFIFO_DEPTH
) (
    input  logic      clk,
    input  logic      clrn,
    input  logic      push_i,
    input  logic      pop_i,
    input  wr_entry_t din_i,
    output wr_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int PW = $clog2(DEPTH);

    wr_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [PW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = cnt_q == (PW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rp_q];

    always_ff @(posedge clk or negedge clrn)
        if (!clrn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_q + PW'(do_push);
            rp_q  <= rp_q + PW'(do_pop);
            cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end

    always_ff @(posedge clk)
        if (do_push) mem_q[wp_q] <= din_i;
endmodule

// File: rtl/vram_arb.sv
// vram_arb: one RAM slot per cycle shared by display scan-out, buffered writes and host reads
// (priority display > write drain > host read).
module vram_arb
    import vram_pkg::*;
(
    input  logic              vga_clk,
    input  logic              clrn,
    input  logic              disp_rdn,
    input  logic [ROW_W-1:0]  disp_row,
    input  logic [COL_W-1:0]  disp_col,
    output logic [PIX_W-1:0]  disp_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ROW_W-1:0]  rd_row,
    input  logic [COL_W-1:0]  rd_col,
    output logic              rd_data_valid,
    output logic [PIX_W-1:0]  rd_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [PIX_W-1:0]  ram_din,
    input  logic [PIX_W-1:0]  ram_dout,
    output logic [7:0]        err_cnt,
    output logic              dbg_state
);
    wr_entry_t         head;
    logic              full, empty, head_ok;
    logic              disp_slot, drain_slot, rd_slot;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PIX_W-1:0]  rd_data_q;
    logic              rd_valid_q, rd_oor_q, rd_oor_d;
    logic [7:0]        err_q, err_d;
    logic [0:0]        state_q, state_d;

    vram_wfifo #(.DEPTH(WFIFO_DEPTH)) u_wfifo (
        .clk     (vga_clk),
        .clrn    (clrn),
        .push_i  (wr_valid),
        .pop_i   (drain_slot),
        .din_i   ({wr_row, wr_col, wr_data}),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // Slots are gated by clrn so nothing reaches the RAM while reset is held.
    assign disp_slot  = clrn && !disp_rdn;
    assign drain_slot = clrn && disp_rdn && !empty;
    assign rd_slot    = clrn && disp_rdn && empty && rd_valid;
    assign head_ok    = on_screen(head.row, head.col);

    assign addr_d = disp_slot  ? {disp_row, disp_col} :
                    drain_slot ? {head.row, head.col} :
                    rd_slot    ? {rd_row, rd_col}     : addr_q;

    assign ram_addr      = addr_d;
    assign ram_we        = drain_slot && head_ok;
    assign ram_din       = head.data;
    assign wr_ready      = !full;
    assign rd_ready      = rd_slot;
    assign disp_data     = ram_dout;
    assign rd_data_valid = rd_valid_q;
    assign rd_data       = rd_valid_q ? (rd_oor_q ? '0 : ram_dout) : rd_data_q;
    assign err_cnt       = err_q;
    assign dbg_state     = state_q;

    assign rd_oor_d = !on_screen(rd_row, rd_col);
    assign err_d    = (drain_slot && !head_ok && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    assign state_d  = disp_rdn ? ST_FREE : ST_DISP;

    always_ff @(posedge vga_clk or negedge clrn)
        if (!clrn) begin
            addr_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_oor_q   <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= '0;
            state_q    <= ST_DISP;
        end else begin
            addr_q     <= addr_d;
            rd_valid_q <= rd_slot;
            rd_oor_q   <= rd_oor_d;
            rd_data_q  <= rd_data;
            err_q      <= err_d;
            state_q    <= state_d;
        end
endmodule

// File: tb/tb_vram_arb.sv
// tb_vram_arb: directed bench for vram_arb with a 1-cycle-latency RAM model; unwritten
// locations read back a fixed address-derived pattern so forced zeros are observable.
module tb_vram_arb;
    logic        vga_clk = 1'b0;
    logic        clrn, disp_rdn, wr_valid, wr_ready, rd_valid, rd_ready, rd_data_valid, ram_we, dbg_state;
    logic [8:0]  disp_row, wr_row, rd_row;
    logic [9:0]  disp_col, wr_col, rd_col;
    logic [11:0] disp_data, wr_data, rd_data, ram_din, ram_dout;
    logic [18:0] ram_addr;
    logic [7:0]  err_cnt;
    logic [11:0] mem [0:524287];
    bit          wflag [0:524287];
    int          wcount = 0;
    int          nchk = 0, nerr = 0;
    int          w0;

    vram_arb dut (
        .vga_clk(vga_clk), .clrn(clrn), .disp_rdn(disp_rdn), .disp_row(disp_row), .disp_col(disp_col),
        .disp_data(disp_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_din(ram_din), .ram_dout(ram_dout), .err_cnt(err_cnt), .dbg_state(dbg_state)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) begin
        ram_dout <= wflag[ram_addr] ? mem[ram_addr] : ram_addr[11:0] ^ 12'h5A5;
        if (ram_we) begin
            mem[ram_addr]   <= ram_din;
            wflag[ram_addr] <= 1'b1;
            wcount          <= wcount + 1;
        end
    end

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [8:0] r, input logic [9:0] c, input logic [11:0] d);
        wr_valid = 1'b1;
        wr_row   = r;
        wr_col   = c;
        wr_data  = d;
    endtask

    initial begin
        clrn = 1'b0; disp_rdn = 1'b1; disp_row = '0; disp_col = '0;
        wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
        rd_valid = 1'b1; rd_row = '0; rd_col = '0;
        repeat (2) tick();
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_rd_data_valid", rd_data_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_rd_ready", rd_ready, 0);
        rd_valid = 1'b0;
        clrn = 1'b1;
        tick();

        // display holds the slot while the FIFO fills
        disp_rdn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push(9'd1, 10'(k), 12'(k + 1));
            #1;
            chk("fill_wr_ready", wr_ready, (k < 4) ? 1 : 0);
            chk("fill_ram_we", ram_we, 0);
            tick();
        end
        wr_valid = 1'b0;
        #1;
        chk("fill_no_writes", wcount, 0);
        chk("fill_full", wr_ready, 0);
        chk("fill_state_disp", dbg_state, 0);
        disp_rdn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_we", ram_we, 1);
            chk("drain_addr", ram_addr, {9'd1, 10'(k)});
            chk("drain_din", ram_din, 12'(k + 1));
            tick();
        end
        #1;
        chk("drain_done_we", ram_we, 0);
        chk("drain_count", wcount, 4);
        chk("drain_wr_ready", wr_ready, 1);
        chk("drain_state_free", dbg_state, 1);

        // display beats a pending write to the same pixel
        disp_rdn = 1'b0; disp_row = 9'd0; disp_col = 10'd639;
        push(9'd0, 10'd639, 12'h5A5);
        #1;
        chk("disp_addr", ram_addr, {9'd0, 10'd639});
        chk("disp_we", ram_we, 0);
        tick();
        wr_valid = 1'b0;
        #1;
        chk("disp_wins_we", ram_we, 0);
        chk("disp_data_old", disp_data, 12'h7DA);
        tick();
        disp_rdn = 1'b1;
        #1;
        chk("disp_then_drain_we", ram_we, 1);
        chk("disp_then_drain_din", ram_din, 12'h5A5);
        tick();
        disp_rdn = 1'b0;
        tick();
        #1;
        chk("disp_data_new", disp_data, 12'h5A5);
        disp_rdn = 1'b1;
        #1;
        chk("idle_addr_hold", ram_addr, {9'd0, 10'd639});
        chk("idle_we", ram_we, 0);
        tick();

        // read-after-write ordering
        push(9'd10, 10'd20, 12'hABC);
        tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_row = 9'd10; rd_col = 10'd20;
        #1;
        chk("raw_rd_blocked", rd_ready, 0);
        chk("raw_drain_we", ram_we, 1);
        chk("raw_drain_addr", ram_addr, {9'd10, 10'd20});
        tick();
        #1;
        chk("raw_grant", rd_ready, 1);
        chk("raw_grant_addr", ram_addr, {9'd10, 10'd20});
        chk("raw_not_yet_valid", rd_data_valid, 0);
        tick();
        rd_valid = 1'b0;
        #1;
        chk("raw_valid", rd_data_valid, 1);
        chk("raw_data", rd_data, 12'hABC);
        tick();
        #1;
        chk("raw_valid_pulse", rd_data_valid, 0);
        chk("raw_data_hold", rd_data, 12'hABC);

        // off-screen host read returns zero
        rd_valid = 1'b1; rd_row = 9'd480; rd_col = 10'd5;
        #1;
        chk("oor_grant", rd_ready, 1);
        tick();
        rd_valid = 1'b0;
        #1;
        chk("oor_valid", rd_data_valid, 1);
        chk("oor_data", rd_data, 0);
        tick();

        // dropped writes and err_cnt saturation
        push(9'd480, 10'd0, 12'h111);
        tick();
        wr_valid = 1'b0;
        #1;
        chk("drop_row_we", ram_we, 0);
        chk("drop_row_err_pre", err_cnt, 0);
        tick();
        #1;
        chk("drop_row_err", err_cnt, 1);
        push(9'd0, 10'd640, 12'h222);
        tick();
        wr_valid = 1'b0;
        tick();
        #1;
        chk("drop_col_err", err_cnt, 2);
        push(9'd479, 10'd639, 12'hBEE);
        tick();
        wr_valid = 1'b0;
        #1;
        chk("corner_we", ram_we, 1);
        chk("corner_addr", ram_addr, {9'd479, 10'd639});
        tick();
        #1;
        chk("corner_err", err_cnt, 2);
        w0 = wcount;
        push(9'd480, 10'd0, 12'h333);
        repeat (300) tick();
        wr_valid = 1'b0;
        repeat (4) tick();
        #1;
        chk("sat_err", err_cnt, 255);
        chk("sat_no_writes", wcount, w0);

        // reset with a host read in flight and a queued write
        w0 = wcount;
        rd_valid = 1'b1; rd_row = 9'd10; rd_col = 10'd20;
        push(9'd2, 10'd2, 12'h777);
        #1;
        chk("rstA_grant", rd_ready, 1);
        tick();
        rd_valid = 1'b0; disp_rdn = 1'b0;
        push(9'd2, 10'd3, 12'h778);
        #1;
        chk("rstA_inflight", rd_data_valid, 1);
        clrn = 1'b0;
        #1;
        chk("rstA_valid_clr", rd_data_valid, 0);
        chk("rstA_wr_ready", wr_ready, 1);
        chk("rstA_ram_we", ram_we, 0);
        chk("rstA_ram_addr", ram_addr, 0);
        wr_valid = 1'b0;
        tick();
        clrn = 1'b1; disp_rdn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rstA_no_valid", rd_data_valid, 0);
            chk("rstA_no_we", ram_we, 0);
            tick();
        end

        // reset with three queued writes and a pending host read
        disp_rdn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push(9'd3, 10'(k), 12'h900 + 12'(k));
            tick();
        end
        wr_valid = 1'b0; rd_valid = 1'b1;
        #1;
        clrn = 1'b0;
        #1;
        chk("rstB_rd_ready", rd_ready, 0);
        chk("rstB_ram_addr", ram_addr, 0);
        tick();
        clrn = 1'b1; disp_rdn = 1'b1; rd_valid = 1'b0;
        #1;
        chk("rstB_wr_ready", wr_ready, 1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rstB_no_we", ram_we, 0);
            chk("rstB_no_valid", rd_data_valid, 0);
            tick();
        end
        chk("rst_no_writes", wcount, w0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
